// File: rtl/sic_dispatch_queue_pkg.sv
// sic_dispatch_queue_pkg: shared packet types for the dispatch queue and the
// sub-SICs it feeds. Packet field widths come from the localparams below.
package sic_dispatch_queue_pkg;

   localparam int SIC_NUM_PHY_REGS = 64;
   localparam int SIC_NUM_ECRS     = 8;
   localparam int SIC_ID_WIDTH     = 6;
   localparam int SIC_PREG_W       = $clog2(SIC_NUM_PHY_REGS);
   localparam int SIC_ECR_W        = $clog2(SIC_NUM_ECRS);

   // Execution class of a decoded instruction; selects which sub-SIC may take it.
   typedef enum logic [1:0] {
      SIC_CLS_IMM,
      SIC_CLS_ALU,
      SIC_CLS_BR,
      SIC_CLS_MEM
   } sic_class_e;

   typedef struct packed {
      sic_class_e             sic_class;
      logic [7:0]             opcode;
      logic [SIC_ECR_W-1:0]   ecr;
      logic [15:0]            imm;
   } sic_info_t;

   typedef struct packed {
      logic                    valid;
      logic [SIC_ID_WIDTH-1:0] id;
      sic_info_t               info;
      logic [SIC_PREG_W-1:0]   rd;
      logic [SIC_PREG_W-1:0]   rs1;
      logic [SIC_PREG_W-1:0]   rs2;
   } sic_packet_t;

   // Round-robin successor of slot idx among n slots.
   function automatic int sic_rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sic_dispatch_queue_rr_pick.sv
// sic_rr_pick: combinational round-robin finder. Returns a one-hot grant for
// the first set mask bit at or after i_ptr, wrapping modulo N.
module sic_rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_mask,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic          o_valid
);

   logic [PW-1:0] w_idx;

   // Scan from the pointer outward; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_idx = PW'((int'(i_ptr) + i) % N);
         if (!o_valid && i_mask[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_valid        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sic_dispatch_queue.sv
// sic_dispatch_queue: in-order packet queue feeding the sub-SICs. The head
// packet goes to one idle, requesting sub-SIC of its class per cycle, chosen
// round-robin, as a registered one-cycle valid pulse.
// Optional: define SIC_DISPATCH_STATS_EN to add stall_cycles / dispatched counters.
module sic_dispatch_queue
   import sic_dispatch_queue_pkg::*;
#(
   parameter int         NUM_PHY_REGS         = SIC_NUM_PHY_REGS,
   parameter int         NUM_ECRS             = SIC_NUM_ECRS,
   parameter int         ID_WIDTH             = SIC_ID_WIDTH,
   parameter int         DEPTH                = 4,
   parameter int         NUM_SUBS             = 4,
   parameter sic_class_e SLOT_CLASS [NUM_SUBS] = '{SIC_CLS_IMM, SIC_CLS_ALU, SIC_CLS_BR, SIC_CLS_MEM}
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  sic_packet_t            enq_pkt,
   output logic                   enq_ready,
   input  logic [NUM_SUBS-1:0]    sub_req,
   output sic_packet_t            sub_pkt [NUM_SUBS],
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count
`ifdef SIC_DISPATCH_STATS_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [31:0]            dispatched
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;

   // The packet layout is fixed by the package; reject a mismatched build early.
   if (NUM_PHY_REGS != SIC_NUM_PHY_REGS || NUM_ECRS != SIC_NUM_ECRS ||
       ID_WIDTH != SIC_ID_WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
      $error("sic_dispatch_queue: unsupported parameter combination");
   end

   sic_packet_t          r_mem [DEPTH];
   logic [AW-1:0]        r_head;
   logic [AW-1:0]        r_tail;
   logic [CW-1:0]        r_count;
   logic [PW-1:0]        r_rr;
   sic_packet_t          r_out [NUM_SUBS];

   sic_packet_t          w_head;
   sic_packet_t          w_head_out;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_disp_any;
   logic [NUM_SUBS-1:0]  w_elig;
   logic [NUM_SUBS-1:0]  w_grant;
   logic [PW-1:0]        w_grant_idx;

   // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
   assign enq_ready = (r_count < CW'(DEPTH));
   assign w_push    = enq_pkt.valid && enq_ready && !flush;
   assign w_pop     = w_disp_any && !flush;
   assign count     = r_count;

   // Head packet as it will appear on the chosen sub-SIC port.
   always_comb begin
      w_head           = r_mem[r_head];
      w_head_out       = w_head;
      w_head_out.valid = 1'b1;
   end

   // A slot is eligible when it asks for work, is not mid-pulse, and matches the head's class.
   always_comb begin
      w_elig = '0;
      for (int k = 0; k < NUM_SUBS; k++)
         w_elig[k] = sub_req[k] && !r_out[k].valid &&
                     (SLOT_CLASS[k] == w_head.info.sic_class) && (r_count != '0);
   end

   sic_rr_pick #(
      .N  (NUM_SUBS),
      .PW (PW)
   ) u_pick (
      .i_mask  (w_elig),
      .i_ptr   (r_rr),
      .o_grant (w_grant),
      .o_valid (w_disp_any)
   );

   // One-hot grant to slot index for the round-robin update.
   always_comb begin
      w_grant_idx = '0;
      for (int k = 0; k < NUM_SUBS; k++)
         if (w_grant[k]) w_grant_idx = PW'(k);
   end

   // Queue pointers, occupancy and round-robin pointer; flush empties but keeps the RR position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_rr    <= '0;
      end else if (flush) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + AW'(1);
         if (w_pop) begin
            r_head <= r_head + AW'(1);
            r_rr   <= PW'(sic_rr_next(int'(w_grant_idx), NUM_SUBS));
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   // Packet storage needs no reset; occupancy tracks which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= enq_pkt;
   end

   // Output pulses: the granted slot gets the head, every other slot drops valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_SUBS; k++) r_out[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_SUBS; k++) begin
            if (w_pop && w_grant[k]) r_out[k]       <= w_head_out;
            else                     r_out[k].valid <= 1'b0;
         end
      end
   end

   assign sub_pkt = r_out;

`ifdef SIC_DISPATCH_STATS_EN
   logic [31:0] r_stall;
   logic [31:0] r_disp;

   // Stall counts cycles with queued work but nothing leaving; flush leaves both counters alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
         r_disp  <= '0;
      end else begin
         if ((r_count != '0) && !w_pop && (r_stall != 32'hFFFF_FFFF)) r_stall <= r_stall + 32'd1;
         if (w_pop) r_disp <= r_disp + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
   assign dispatched   = r_disp;
`endif

endmodule
